// File: rtl/rr_sched_w1024_pkg.sv
// Shared defaults, FSM state encoding and the one-hot to binary index encode
// used by the round-robin grant scheduler.
package rr_sched_w1024_pkg;

    localparam int N_DEF     = 1024;
    localparam int LOG2N_DEF = $clog2(N_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // OR-reduction of set-bit indices; exact for a one-hot (or zero) input.
    function automatic logic [LOG2N_DEF-1:0] onehot2idx(input logic [N_DEF-1:0] oh);
        logic [LOG2N_DEF-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_DEF; i++) begin
            if (oh[i]) idx = idx | LOG2N_DEF'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_sched_w1024_ppe_core.sv
// Programmable priority encoder: lowest request at or above the pointer, else lowest overall.
// Purely combinational; no latency, no backpressure.
module rr_sched_w1024_ppe_core
    import rr_sched_w1024_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LOG2N = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [LOG2N-1:0] pointer,
    output logic [N-1:0]     gnt,
    output logic             any_vld
);

    logic [N-1:0] mask;
    logic [N-1:0] req_m;
    logic [N-1:0] gnt_m;
    logic [N-1:0] gnt_u;

    assign mask  = {N{1'b1}} << pointer;
    assign req_m = req & mask;

    // x & -x isolates the lowest set bit of each candidate vector.
    assign gnt_m = req_m & (~req_m + N'(1));
    assign gnt_u = req & (~req + N'(1));

    assign gnt     = (|req_m) ? gnt_m : gnt_u;
    assign any_vld = |req;

endmodule

// File: rtl/rr_sched_w1024.sv
// Round-robin / fixed-priority grant scheduler over 1024 requesters with a hold timer.
// Grant 1 cycle after a request is seen in IDLE; at least one IDLE cycle between grants.
module rr_sched_w1024
    import rr_sched_w1024_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int LOG2N    = $clog2(N),
    parameter int MAX_HOLD = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             done,
    input  logic             cfg_rr_en,
    input  logic             cfg_ptr_wr,
    input  logic [LOG2N-1:0] cfg_ptr,
    output logic [N-1:0]     gnt,
    output logic [LOG2N-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout,
    output logic [LOG2N-1:0] ptr
);

    localparam int CW = $clog2(MAX_HOLD + 2);
    localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [LOG2N-1:0] idx_q, idx_d;
    logic             vld_q, vld_d;
    logic             tmo_q, tmo_d;
    logic [LOG2N-1:0] ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [N-1:0]     ppe_gnt;
    logic             ppe_any;
    logic [LOG2N-1:0] ppe_ptr;
    logic [LOG2N-1:0] ppe_idx;
    logic             rel_owner;
    logic             rel_timer;

    assign ppe_ptr = cfg_rr_en ? ptr_q : '0;

    rr_sched_w1024_ppe_core #(.N(N), .LOG2N(LOG2N)) u_ppe (
        .req     (req),
        .pointer (ppe_ptr),
        .gnt     (ppe_gnt),
        .any_vld (ppe_any)
    );

    assign ppe_idx   = LOG2N'(onehot2idx(N_DEF'(ppe_gnt)));
    assign rel_owner = done || !req[idx_q];
    assign rel_timer = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        tmo_d   = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ppe_any) begin
                    gnt_d   = ppe_gnt;
                    idx_d   = ppe_idx;
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (rel_owner || rel_timer) begin
                    gnt_d   = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                    tmo_d   = !rel_owner;
                    state_d = IDLE;
                    if (cfg_rr_en) ptr_d = idx_q + LOG2N'(1);
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // A software pointer load wins over the release-time update.
        if (cfg_ptr_wr) ptr_d = cfg_ptr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            tmo_q   <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            tmo_q   <= tmo_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = vld_q;
    assign timeout   = tmo_q;
    assign ptr       = ptr_q;

endmodule

// File: tb/tb_rr_sched_w1024.sv
// Directed bench for rr_sched_w1024 (MAX_HOLD=16): expected grant indices are queued
// when requests are driven and popped when the scheduler raises gnt_valid.
module tb_rr_sched_w1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1023:0] req;
    logic          done;
    logic          cfg_rr_en;
    logic          cfg_ptr_wr;
    logic [9:0]    cfg_ptr;
    logic [1023:0] gnt;
    logic [9:0]    gnt_idx;
    logic          gnt_valid;
    logic          timeout;
    logic [9:0]    ptr;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int lat;
    int hi;

    rr_sched_w1024 #(.N(1024), .LOG2N(10), .MAX_HOLD(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .cfg_rr_en  (cfg_rr_en),
        .cfg_ptr_wr (cfg_ptr_wr),
        .cfg_ptr    (cfg_ptr),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid),
        .timeout    (timeout),
        .ptr        (ptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until gnt_valid rises (bounded), then checks against the scoreboard head.
    task automatic wait_grant(input string tag, output int lat_o);
        int            e;
        logic [1023:0] eg;
        lat_o = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (gnt_valid === 1'b1) begin
                lat_o = i;
                break;
            end
        end
        if (lat_o == 0) begin
            check({tag, "_no_grant"}, 32'(gnt_valid), 32'd1);
        end else if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_idx"}, 32'(gnt_idx), 32'(e));
            eg    = '0;
            eg[e] = 1'b1;
            checks++;
            assert (gnt === eg) else begin
                errors++;
                $error("FAIL %s_onehot observed_ones=%0d observed_idx=%0d expected_idx=%0d",
                       tag, $countones(gnt), gnt_idx, e);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = '1;
        done       = 1'b0;
        cfg_rr_en  = 1'b1;
        cfg_ptr_wr = 1'b0;
        cfg_ptr    = '0;

        // 1. reset with all requesters active
        repeat (3) step();
        check("rst_gnt_ones", 32'($countones(gnt)), 32'd0);
        check("rst_gnt_valid", 32'(gnt_valid), 32'd0);
        check("rst_ptr", 32'(ptr), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        exp_q.push_back(0);
        wait_grant("post_rst", lat);
        check("post_rst_lat", 32'(lat), 32'd1);
        req = '0;
        step();
        check("post_rst_rel_vld", 32'(gnt_valid), 32'd0);
        check("post_rst_rel_ptr", 32'(ptr), 32'd1);

        // 2. round-robin over {5,700}
        cfg_ptr_wr = 1'b1; cfg_ptr = 10'd0;
        step();
        cfg_ptr_wr = 1'b0;
        check("rr_ptr_load", 32'(ptr), 32'd0);
        req = '0; req[5] = 1'b1; req[700] = 1'b1;
        exp_q.push_back(5);
        wait_grant("rr_g5", lat);
        check("rr_g5_lat", 32'(lat), 32'd1);
        done = 1'b1;
        step();
        done = 1'b0;
        check("rr_rel5_vld", 32'(gnt_valid), 32'd0);
        check("rr_rel5_ptr", 32'(ptr), 32'd6);
        exp_q.push_back(700);
        wait_grant("rr_g700", lat);
        check("rr_g700_lat", 32'(lat), 32'd1);
        done = 1'b1;
        step();
        done = 1'b0;
        req  = '0;
        check("rr_rel700_ptr", 32'(ptr), 32'd701);

        // 3. pointer wrap at N-1
        cfg_ptr_wr = 1'b1; cfg_ptr = 10'd1023;
        step();
        cfg_ptr_wr = 1'b0;
        check("wrap_ptr_load", 32'(ptr), 32'd1023);
        req = '0; req[3] = 1'b1; req[1023] = 1'b1;
        exp_q.push_back(1023);
        wait_grant("wrap_g1023", lat);
        done = 1'b1;
        step();
        done = 1'b0;
        check("wrap_ptr", 32'(ptr), 32'd0);
        exp_q.push_back(3);
        wait_grant("wrap_g3", lat);
        check("wrap_g3_lat", 32'(lat), 32'd1);

        // 6a. dropping the owner's request releases without a timeout
        req = '0;
        step();
        check("drop_vld", 32'(gnt_valid), 32'd0);
        check("drop_timeout", 32'(timeout), 32'd0);
        check("drop_ptr", 32'(ptr), 32'd4);

        // 4. hold timer expiry
        req = '0; req[10] = 1'b1;
        exp_q.push_back(10);
        wait_grant("tmo_g10", lat);
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (gnt_valid === 1'b1) hi++;
            else break;
        end
        check("tmo_hold_cycles", 32'(hi), 32'd16);
        check("tmo_pulse", 32'(timeout), 32'd1);
        check("tmo_ptr", 32'(ptr), 32'd11);
        exp_q.push_back(10);
        wait_grant("tmo_regrant", lat);
        check("tmo_regrant_lat", 32'(lat), 32'd1);
        check("tmo_pulse_end", 32'(timeout), 32'd0);
        req = '0;
        step();
        check("tmo_drop_ptr", 32'(ptr), 32'd11);

        // 5. fixed priority ignores the pointer
        cfg_rr_en  = 1'b0;
        cfg_ptr_wr = 1'b1; cfg_ptr = 10'd500;
        step();
        cfg_ptr_wr = 1'b0;
        req = '0; req[2] = 1'b1; req[600] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(2);
            wait_grant("fix_g2", lat);
            done = 1'b1;
            step();
            done = 1'b0;
            check("fix_ptr", 32'(ptr), 32'd500);
            check("fix_rel_vld", 32'(gnt_valid), 32'd0);
        end
        req = '0;

        // pointer write beats the release update in the same cycle
        cfg_rr_en = 1'b1;
        req = '0; req[9] = 1'b1;
        exp_q.push_back(9);
        wait_grant("pw_g9", lat);
        done = 1'b1; cfg_ptr_wr = 1'b1; cfg_ptr = 10'd77;
        step();
        done = 1'b0; cfg_ptr_wr = 1'b0;
        check("pw_prio_ptr", 32'(ptr), 32'd77);

        // 6b. asynchronous reset in BUSY
        exp_q.push_back(9);
        wait_grant("arst_g9", lat);
        #2 rst_n = 1'b0;
        #1;
        check("arst_gnt_ones", 32'($countones(gnt)), 32'd0);
        check("arst_vld", 32'(gnt_valid), 32'd0);
        check("arst_ptr", 32'(ptr), 32'd0);
        req = '0;
        step();
        rst_n = 1'b1;
        step();
        check("arst_idle_vld", 32'(gnt_valid), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rr_sched_w1024.md
Name: rr_sched_w1024

Overview:
Round-robin grant scheduler for a 1024-wide requester set, built around a programmable priority encoder (PPE). It holds a rotating priority pointer and issues one registered one-hot grant at a time. Each grant is held until the owner releases it or a hold timer expires. It sits between requesting clients and the shared resource the PPE output selects.

Parameters:
N, 1024, number of requesters; must be a power of two, at least 2.
LOG2N, $clog2(N), width of the pointer and the grant index.
MAX_HOLD, 256, maximum number of cycles a grant may be held; 0 disables the timeout.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
req  in  N  request vector; bit i is requester i
done  in  1  single-cycle release pulse from the current grant owner
cfg_rr_en  in  1  1 = round-robin, 0 = fixed priority (index 0 highest)
cfg_ptr_wr  in  1  load the priority pointer
cfg_ptr  in  LOG2N  value loaded into the pointer
gnt  out  N  registered one-hot grant
gnt_idx  out  LOG2N  binary index of gnt
gnt_valid  out  1  high while a grant is held
timeout  out  1  one-cycle pulse on a forced release
ptr  out  LOG2N  current priority pointer

Behaviour:
- Reset (asynchronous, rst_n=0) forces immediately:
  - state=IDLE
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0
  - hold counter=0
- PPE function (combinational): select the lowest set bit of req at index >= pointer; if none, select the lowest set bit overall. The PPE pointer input is ptr when cfg_rr_en=1 and 0 when cfg_rr_en=0.
- IDLE:
  - If req != 0, register the PPE result into gnt and gnt_idx, set gnt_valid=1, clear the hold counter, go to BUSY.
  - Grant latency is 1 cycle from req seen in IDLE.
- BUSY:
  - gnt and gnt_idx stay frozen; req changes on other bits are ignored.
  - Release condition is any of: done=1; req[gnt_idx]=0; hold counter = MAX_HOLD-1 with MAX_HOLD != 0.
  - On release (registered): gnt=0, gnt_valid=0, go to IDLE.
  - On release with cfg_rr_en=1: ptr <= gnt_idx+1, modulo N, so N-1 wraps to 0.
  - On release with cfg_rr_en=0: ptr unchanged.
  - If the release is due only to the timer (no done, req still high), timeout pulses for 1 cycle, aligned with gnt_valid falling.
  - Otherwise the hold counter increments each BUSY cycle and saturates; it never wraps.
- Turnaround: there is always at least one IDLE cycle between grants, so maximum throughput is one grant per 2 cycles.
- done while in IDLE is ignored.
- cfg_ptr_wr in any state: ptr <= cfg_ptr next cycle. It takes priority over a release update in the same cycle. The current grant is unaffected.
- done and timer expiry in the same cycle: a normal release, no timeout pulse.
- Mode change in BUSY: takes effect at the pointer update of the next release.
- gnt_idx always equals the encode of gnt when gnt_valid=1, and is 0 otherwise.

Decomposition:
- Shared package: N and LOG2N defaults, state encoding (IDLE=1'b0, BUSY=1'b1), and a function giving the one-hot-to-index encode.
- Sub-module ppe_core (parameter N): purely combinational programmable priority encoder.
  - Inputs: req, pointer. Outputs: one-hot grant, any-valid.
  - Built as a two-level split: a thermometer mask of the pointer plus two simple priority encoders, one masked and one unmasked.
  - Selection rule: use the masked result if it is valid, else the unmasked result.
- All sequencing (FSM, hold counter, pointer register, output registers) lives in rr_sched_w1024.

Test Plan:
1. Hold rst_n=0 for 3 cycles with req=all-ones -> gnt=0, gnt_valid=0, ptr=0. Release reset, wait 1 cycle -> gnt_idx=0, gnt_valid=1.
2. cfg_rr_en=1, ptr=0, req bits {5,700} -> gnt_idx=5 one cycle later. Pulse done -> ptr=6, gnt_valid=0 for 1 cycle, then gnt_idx=700. Pulse done -> ptr=701.
3. Wrap case: cfg_ptr_wr with cfg_ptr=1023, req bits {3,1023} -> gnt_idx=1023. Pulse done -> ptr=0, next gnt_idx=3.
4. MAX_HOLD=16, req bit 10 held high, done never asserted -> gnt_valid high for exactly 16 cycles. Then timeout=1 for one cycle, ptr=11, and bit 10 is regranted after 1 IDLE cycle.
5. cfg_rr_en=0, cfg_ptr=500, req bits {2,600}, done pulsed after each grant -> gnt_idx=2 every grant; ptr stays 500.
6. Mid-BUSY: drop req[gnt_idx] without done -> normal release, timeout=0. Separately, assert rst_n=0 mid-BUSY -> gnt=0 and gnt_valid=0 in the same cycle, ptr=0.
